// File: rtl/param_stream_mux.sv
// param_stream_mux: registered N-channel stream multiplexer with valid/ready
// handshake and a one-entry output register. Selection is either explicit
// (mode=0, channel sel) or round-robin (mode=1, starting at rr_ptr).
// Optional packet locking is compiled in with PARAM_STREAM_MUX_PKT_LOCK_EN:
// a word with in_last=0 holds the grant on its channel until the word with
// in_last=1 from that channel has been transferred.
module param_stream_mux #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SELW = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]   in_last,
    output logic              out_last,
`endif
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    input  logic              out_ready
);

    // Output register and arbitration state
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_ch_q,    out_ch_d;
    logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    logic            out_last_q,  out_last_d;
    logic            lock_q,      lock_d;
    logic [SELW-1:0] lock_ch_q,   lock_ch_d;
`endif

    // Unpacked view of the input data bus, one entry per channel
    logic [W-1:0] ch_data [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    logic            load_en;
    logic            grant_any;
    logic [SELW-1:0] grant_ch;
    logic            xfer;
    logic            pkt_final;
    int              scan_idx;
    logic [SELW-1:0] scan_ch;

    // The register can take a word when it is empty or is being drained now
    assign load_en = !out_valid_q || out_ready;

    // Grant selection: packet lock overrides mode, otherwise explicit or round-robin scan
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        scan_idx  = 0;
        scan_ch   = '0;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            grant_any = in_valid[lock_ch_q];
            grant_ch  = lock_ch_q;
        end else
`endif
        if (!mode) begin
            // Out-of-range select (non-power-of-2 channel count) grants nothing
            if (int'(sel) < N_CH) begin
                grant_any = in_valid[sel];
                grant_ch  = sel;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                scan_idx = (int'(rr_ptr_q) + i) % N_CH;
                scan_ch  = SELW'(scan_idx);
                if (!grant_any && in_valid[scan_ch]) begin
                    grant_any = 1'b1;
                    grant_ch  = scan_ch;
                end
            end
        end
    end

    assign xfer = !rst && load_en && grant_any;

    // Ready is one-hot on the granted channel, and all-zero while in reset
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_ch] = 1'b1;
        end
    end

    // Next-state for the output register, round-robin pointer and packet lock
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_final   = 1'b1;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        pkt_final   = in_last[grant_ch];
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_ch];
            out_ch_d    = grant_ch;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            out_last_d  = in_last[grant_ch];
            lock_d      = !in_last[grant_ch];
            lock_ch_d   = grant_ch;
`endif
            // Pointer only advances on the final word of a packet in round-robin mode
            if (mode && pkt_final) begin
                if (int'(grant_ch) == N_CH - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_ch + SELW'(1);
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding any held word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_param_stream_mux.sv
// Testbench for param_stream_mux: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_param_stream_mux;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    in_last;
    logic            out_last;
    logic            mode;
    logic [SELW-1:0] sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_ready;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    param_stream_mux #(.N_CH(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );
`ifndef PARAM_STREAM_MUX_PKT_LOCK_EN
    assign out_last = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents of the output slot plus arbitration memory
    logic         m_valid = 1'b0, n_valid;
    logic [W-1:0] m_data  = '0,   n_data;
    int           m_ch    = 0,    n_ch;
    logic         m_last  = 1'b0, n_last;
    int           m_rr    = 0,    n_rr;
    logic         m_lock  = 1'b0, n_lock;
    int           m_lock_ch = 0,  n_lock_ch;
    logic [N-1:0] xfer_mask = '0;

    // Candidate channels in priority order; the first valid one wins
    function automatic int model_grant();
        int cand[$];
        if (m_lock) cand.push_back(m_lock_ch);
        else if (mode == 1'b0) cand.push_back(int'(sel));
        else for (int i = 0; i < N; i++) cand.push_back((m_rr + i) % N);
        foreach (cand[j]) if (cand[j] < N && in_valid[cand[j]]) return cand[j];
        return -1;
    endfunction

    // Per-cycle compare against the model, then compute model next state
    always @(negedge clk) begin : cmp
        int g;
        logic [N-1:0] er;
        logic fin;
        g  = model_grant();
        er = '0;
        if (!rst && (!m_valid || out_ready) && g >= 0) er[g] = 1'b1;
        if (cyc > 0) begin
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            chk("out_last", 32'(out_last), 32'(m_last));
`endif
        end
        xfer_mask = er;
        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_last = m_last;
        n_rr = m_rr; n_lock = m_lock; n_lock_ch = m_lock_ch;
        if (rst) begin
            n_valid = 1'b0; n_data = '0; n_ch = 0; n_last = 1'b0;
            n_rr = 0; n_lock = 1'b0; n_lock_ch = 0;
        end else if (er != '0) begin
            n_valid = 1'b1;
            n_data  = in_data[g*W +: W];
            n_ch    = g;
            fin     = 1'b1;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            fin       = in_last[g];
            n_last    = in_last[g];
            n_lock    = !in_last[g];
            n_lock_ch = g;
`endif
            if (mode && fin) n_rr = (g + 1) % N;
        end else if (out_ready) begin
            n_valid = 1'b0;
        end
    end

    // Model state advances on the same edge as the DUT
    always @(posedge clk) begin
        cyc++;
        m_valid <= n_valid; m_data <= n_data; m_ch <= n_ch; m_last <= n_last;
        m_rr <= n_rr; m_lock <= n_lock; m_lock_ch <= n_lock_ch;
    end

    initial begin
        int exp_sparse[3];
        exp_sparse = '{3, 1, 3};

        // Reset held with every channel valid
        rst = 1'b1; in_valid = '1; mode = 1'b1; sel = '0; out_ready = 1'b1; in_last = '1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'(8'h10 + k);
        repeat (3) begin
            @(posedge clk); #3;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_ch", 32'(out_ch), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        rst = 1'b0; #1;
        chk("first_grant", 32'(in_ready), 32'b0001);

        // Round-robin with all channels valid: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_ch", 32'(out_ch), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'(8'h10 + i % 4));
        end

        // Sparse round-robin, pointer now at 2: expect 3,1,3 with sel ignored
        in_valid = 4'b1010; sel = 2'd2; #1;
        chk("sparse_ready0", 32'(in_ready), 32'b1000);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #3;
            chk("sparse_ch", 32'(out_ch), 32'(exp_sparse[j]));
            sel = 2'($urandom);
            if (j < 2) begin
                #1;
                chk("sparse_ready", 32'(in_ready), 32'(1 << exp_sparse[j + 1]));
            end
        end

        // Explicit select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data[2*W +: W] = 8'hA5; #1;
        chk("expl_ready", 32'(in_ready), 32'b0100);
        @(posedge clk); #3;
        chk("expl_valid", 32'(out_valid), 32'd1);
        chk("expl_data", 32'(out_data), 32'hA5);
        chk("expl_ch", 32'(out_ch), 32'd2);

        // Backpressure: held word stable, no ready for 5 cycles
        out_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #3;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_ch", 32'(out_ch), 32'd2);
        end
        // Drain and refill in the same cycle
        sel = 2'd1; in_data[1*W +: W] = 8'h3C; out_ready = 1'b1; #1;
        chk("drain_ready", 32'(in_ready), 32'b0010);
        @(posedge clk); #3;
        chk("drain_data", 32'(out_data), 32'h3C);
        chk("drain_ch", 32'(out_ch), 32'd1);

`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        // Three-word packet from ch0 while ch1 waits; pointer is 0
        mode = 1'b1; in_valid = 4'b0011; in_last = 4'b0010; in_data[0 +: W] = 8'hA0; #1;
        chk("pkt_ready", 32'(in_ready), 32'b0001);
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #3;
            chk("pkt_ch", 32'(out_ch), 32'd0);
            chk("pkt_data", 32'(out_data), 32'(8'hA0 + w));
            chk("pkt_last", 32'(out_last), 32'(w == 2));
            if (w < 2) begin
                in_data[0 +: W] = 8'(8'hA1 + w);
                in_last[0] = (w + 1 == 2);
            end
        end
        @(posedge clk); #3;
        chk("pkt_next_ch", 32'(out_ch), 32'd1);
        chk("pkt_next_last", 32'(out_last), 32'd1);
`endif

        // Randomized traffic; producers hold words until transferred
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #3;
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if (!in_valid[k] || xfer_mask[k]) begin
                    in_valid[k] = ($urandom_range(0, 2) != 0);
                    in_data[k*W +: W] = 8'($urandom);
                    in_last[k] = ($urandom_range(0, 2) == 0);
                end
            end
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #3;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/param_stream_mux.md
Name: param_stream_mux

Overview:
- Parametrised, registered N-channel stream multiplexer; successor to the plain 2:1 combinational mux.
- Generalised in width (W) and channel count (N_CH).
- Adds a valid/ready handshake, a one-entry output register, and two selection modes: explicit select and round-robin.
- Sits between several producer streams and one consumer, e.g. merging request sources onto a shared bus.

Parameters:
- N_CH, 4, number of input channels (>= 2).
- W, 8, data width per channel.
- SELW, $clog2(N_CH), width of select/channel-id fields (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*W  packed data; channel k occupies bits [k*W +: W].
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SELW  channel index used when mode=0.
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered data.
- out_ch  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - Any held word is discarded.
  - in_ready is all-zero while rst=1.
- load_en = !out_valid | out_ready (combinational). The register accepts a new word when empty or being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: grant channel sel iff in_valid[sel]=1. If sel >= N_CH (non-power-of-2 N_CH), no grant.
  - mode=1: grant the first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
  - No valid channel: no grant.
- in_ready[k] = load_en & grant[k]. A transfer from channel k happens when in_valid[k] & in_ready[k].
- On a transfer:
  - Next cycle: out_valid=1, out_data=in_data[k], out_ch=k.
  - Latency is exactly 1 cycle; sustained throughput is 1 word/cycle when out_ready=1.
- When out_valid & out_ready and there is no transfer: out_valid goes to 0. out_data and out_ch hold their last values.
- When out_valid=1 and out_ready=0: out_valid, out_data and out_ch are stable, and in_ready is all-zero.
- rr_ptr update:
  - Only on a transfer while mode=1: rr_ptr = (k+1) mod N_CH. Wraps N_CH-1 -> 0.
  - Unchanged on mode=0 transfers.
- Mode or sel changes take effect on the next grant evaluation. A word already in the register is unaffected.
- in_ready is a function of in_valid, so producers must not make in_valid depend on in_ready.
- Producers must hold in_valid and in_data until transfer.

Optional Feature:
- Macro: PARAM_STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (in, N_CH) and out_last (out, 1; reset 0; registered alongside out_data).
  - A transfer with in_last[k]=0 locks the grant to channel k, ignoring mode and sel, until a transfer from k with in_last[k]=1.
  - The rr_ptr update is applied on the packet-final transfer only.
  - rst clears the lock.
- Undefined: no in_last/out_last ports; every word is arbitrated independently.

Test Plan:
- Reset: hold rst=1 with all in_valid=1 for 3 cycles -> in_ready=0, out_valid=0, out_data=0, out_ch=0; after release, first transfer from ch0 in round-robin mode.
- Explicit mode (mode=0, sel=2, N_CH=4, W=8): in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- Round-robin (mode=1): all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle, wrapping 3 -> 0.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> out_data/out_ch stable and in_ready=0; raise out_ready -> held word drains and a new transfer occurs in the same cycle.
- Sparse round-robin: only ch1 and ch3 valid, rr_ptr=2 -> grant ch3, then ch1, then ch3; sel ignored throughout.
- PKT_LOCK_EN: ch0 sends 3 words with in_last=0,0,1 while ch1 is valid -> out_ch=0,0,0 then 1; out_last=1 on the third word only.
